uart_rx_fifo_gen: RTL and testbench
===================================

UART_RX_FIFO_GEN -- requirements
Module: uart_rx_fifo_gen

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16: RX FIFO entries; power of two, 4..256.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16: baud ticks per bit; even, 8..32.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-004 The block SHALL have parameter TIMEOUT_BITS, default 40: character timeout in bit times.
REQ-005 Port clock, in, 1: the single system clock; all logic SHALL be rising-edge clocked.
REQ-006 Port reset, in, 1: synchronous reset, active-high.
REQ-007 Port baudDivisor, in, DIV_WIDTH: clock cycles per oversample tick; 0 stops ticks.
REQ-008 Port rxLine, in, 1: asynchronous serial input, idle high.
REQ-009 Port dataBits, in, 2: character length 0..3 maps to 5..8 bits.
REQ-010 Port parityEnable, in, 1 and port evenParity, in, 1: parity bit present / parity type.
REQ-011 Port threshold, in, log2(FIFO_DEPTH): rxAvailable level.
REQ-012 Port fifoRe, in, 1: pop the head entry; fifoFlush, in, 1: empty the FIFO.
REQ-013 Port dataOut, out, 8: head data, first-word fall-through; frameErrorOut, out, 1 and parityErrorOut, out, 1: head-entry flags.
REQ-014 Ports fifoEmpty, out, 1; fifoFull, out, 1; nrOfEntries, out, log2(FIFO_DEPTH)+1.
REQ-015 Ports overrunError, out, 1 (pulse); breakDetected, out, 1 (pulse); rxAvailable, out, 1; timeoutIrq, out, 1.

Function
REQ-016 The tick counter SHALL load baudDivisor-1 and issue a one-cycle tick at 0, then reload; baudDivisor 0 SHALL hold the counter and issue no ticks.
REQ-017 rxLine SHALL pass through a 2-flop synchronizer reset to 1; all references below use the synchronized value.
REQ-018 The receive FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAKWAIT and SHALL advance only on ticks.
REQ-019 IDLE -> START on a falling edge; in START, if the line is high at tick OVERSAMPLE/2, the FSM SHALL return to IDLE (false start) with no FIFO write.
REQ-020 Each subsequent bit SHALL be sampled OVERSAMPLE ticks after the previous sample; DATA SHALL collect dataBits+5 bits LSB first, zero-filled to 8; DATA -> PARITY if parityEnable, else -> STOP.
REQ-021 parityError SHALL be 1 when the XOR of data bits and the parity bit differs from ~evenParity.
REQ-022 The STOP sample SHALL write {frameErr, parityErr, data} to the FIFO in the same cycle; frameErr = stop bit low.
REQ-023 When all data bits, the parity bit and the stop bit are 0, breakDetected SHALL pulse once; the entry SHALL be written with data 0 and frameErr 1, then the FSM SHALL enter BREAKWAIT until the line is high, then IDLE.
REQ-024 After a frame error without break, the FSM SHALL go to IDLE.
REQ-025 FIFO writes SHALL take priority order flush > read/write: fifoFlush SHALL clear count and pointers and discard a same-cycle write.
REQ-026 A write while full SHALL be dropped and overrunError SHALL pulse for 1 cycle, except when fifoRe is asserted in the same cycle: then both SHALL occur, with count unchanged and no overrun.
REQ-027 fifoRe while empty SHALL be ignored; a same-cycle write to an empty FIFO SHALL be accepted.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; nrOfEntries SHALL reach FIFO_DEPTH when full.
REQ-029 rxAvailable SHALL be combinationally nrOfEntries >= max(threshold,1).
REQ-030 The timeout counter SHALL count ticks while the FIFO is non-empty and the FSM is in IDLE, and SHALL clear on any FIFO write, accepted read, or flush, or when the FIFO is empty.
REQ-031 timeoutIrq SHALL be set when the count reaches TIMEOUT_BITS*OVERSAMPLE, held while set, and cleared under the same conditions that clear the counter.
REQ-032 Configuration inputs changing mid-frame SHALL take effect at the next START.

Reset
REQ-033 reset SHALL force: FSM IDLE; FIFO empty; fifoEmpty 1, fifoFull 0, nrOfEntries 0; dataOut 0, frameErrorOut 0, parityErrorOut 0; overrunError 0, breakDetected 0, timeoutIrq 0; tick and timeout counters 0; synchronizer 1.
REQ-034 reset asserted mid-frame SHALL abort the frame with no FIFO write.

Verification
REQ-035 Scenario: divisor 4, 8N1, send 0xA5 -> one entry 0xA5, flags 0, written about 9.5*64 cycles after the start edge.
REQ-036 Scenario: 7E1, send 0x3C with a corrupted parity bit -> dataOut 0x3C, parityErrorOut 1.
REQ-037 Scenario: FIFO_DEPTH 4, send 5 chars with no reads -> nrOfEntries 4, fifoFull 1, one overrunError pulse, head = first char.
REQ-038 Scenario: FIFO full and fifoRe coincident with the 5th char's stop sample -> count stays 4, no overrun, 5th char at tail.
REQ-039 Scenario: line low for 20 bit times -> single entry 0x00 with frameErr 1, one breakDetected pulse, FSM idle only after line high.
REQ-040 Scenario: one char received, then idle -> timeoutIrq rises at 40*16 ticks after the write; fifoRe clears it; a 2-cycle low glitch produces no entry.

Source files
------------

// File: rtl/uart_rx_fifo_gen.sv
// Oversampling UART receiver feeding a first-word fall-through RX FIFO, with
// overrun, break and character-timeout reporting.
module uart_rx_fifo_gen #(
  parameter int FIFO_DEPTH   = 16,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          baudDivisor,
  input  logic                          rxLine,
  input  logic [1:0]                    dataBits,
  input  logic                          parityEnable,
  input  logic                          evenParity,
  input  logic [$clog2(FIFO_DEPTH)-1:0] threshold,
  input  logic                          fifoRe,
  input  logic                          fifoFlush,
  output logic [7:0]                    dataOut,
  output logic                          frameErrorOut,
  output logic                          parityErrorOut,
  output logic                          fifoEmpty,
  output logic                          fifoFull,
  output logic [$clog2(FIFO_DEPTH):0]   nrOfEntries,
  output logic                          overrunError,
  output logic                          breakDetected,
  output logic                          rxAvailable,
  output logic                          timeoutIrq
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAKWAIT
  } state_t;

  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic                 w_tick;

  logic r_sync1, r_sync2, r_rx_prev, r_fall_pend;
  logic w_rx, w_fall;

  state_t          r_state, w_state_n;
  logic [OS_W-1:0] r_os_cnt, w_os_n;
  logic [2:0]      r_bit_cnt, w_bit_n;
  logic [2:0]      w_last_idx;
  logic            w_latch_cfg;

  logic [7:0] r_data, w_data_n;
  logic       r_par_acc, w_par_n;
  logic       r_all_zero, w_zero_n;
  logic       r_perr, w_perr_n;
  logic [1:0] r_cfg_bits;
  logic       r_cfg_par_en, r_cfg_even;

  logic       w_wr_req, w_brk;
  logic [9:0] w_wr_data;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_thr;
  logic [9:0]    w_head;
  logic          w_empty, w_full, w_rd, w_wr, w_ovr;

  logic            r_ovr, r_brk;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_irq;
  logic            w_to_clr;

  // Baud tick generator: divisor 0 freezes the counter.
  assign w_tick = (baudDivisor != '0) && (r_tick_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (baudDivisor != '0) begin
      if (r_tick_cnt == '0) r_tick_cnt <= baudDivisor - DIV_WIDTH'(1);
      else                  r_tick_cnt <= r_tick_cnt - DIV_WIDTH'(1);
    end
  end

  // Line synchronizer and edge capture; an edge only arms a start while idle.
  assign w_rx   = r_sync2;
  assign w_fall = r_rx_prev & ~r_sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_fall_pend <= 1'b0;
    end else begin
      r_sync1   <= rxLine;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      if (r_state != S_IDLE) r_fall_pend <= 1'b0;
      else if (w_tick)       r_fall_pend <= 1'b0;
      else if (w_fall)       r_fall_pend <= 1'b1;
    end
  end

  assign w_last_idx = {1'b0, r_cfg_bits} + 3'd4;

  always_comb begin
    w_state_n   = r_state;
    w_os_n      = r_os_cnt;
    w_bit_n     = r_bit_cnt;
    w_latch_cfg = 1'b0;
    w_data_n    = r_data;
    w_par_n     = r_par_acc;
    w_zero_n    = r_all_zero;
    w_perr_n    = r_perr;
    w_wr_req    = 1'b0;
    w_brk       = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if ((r_fall_pend || w_fall) && !w_rx) begin
            w_state_n   = S_START;
            w_os_n      = '0;
            w_bit_n     = '0;
            w_latch_cfg = 1'b1;
            w_data_n    = '0;
            w_par_n     = 1'b0;
            w_zero_n    = 1'b1;
            w_perr_n    = 1'b0;
          end
        end
        S_START: begin
          if (r_os_cnt == OS_HALF) begin
            w_os_n    = '0;
            w_state_n = w_rx ? S_IDLE : S_DATA;
          end else begin
            w_os_n = r_os_cnt + OS_W'(1);
          end
        end
        S_DATA: begin
          if (r_os_cnt == OS_LAST) begin
            w_os_n              = '0;
            w_data_n[r_bit_cnt] = w_rx;
            w_par_n             = r_par_acc ^ w_rx;
            w_zero_n            = r_all_zero & ~w_rx;
            if (r_bit_cnt == w_last_idx) w_state_n = r_cfg_par_en ? S_PARITY : S_STOP;
            else                         w_bit_n   = r_bit_cnt + 3'd1;
          end else begin
            w_os_n = r_os_cnt + OS_W'(1);
          end
        end
        S_PARITY: begin
          if (r_os_cnt == OS_LAST) begin
            w_os_n    = '0;
            w_perr_n  = ((r_par_acc ^ w_rx) != ~r_cfg_even);
            w_zero_n  = r_all_zero & ~w_rx;
            w_state_n = S_STOP;
          end else begin
            w_os_n = r_os_cnt + OS_W'(1);
          end
        end
        S_STOP: begin
          if (r_os_cnt == OS_LAST) begin
            w_os_n   = '0;
            w_wr_req = 1'b1;
            if (r_all_zero && !w_rx) begin
              w_brk     = 1'b1;
              w_state_n = S_BREAKWAIT;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_os_n = r_os_cnt + OS_W'(1);
          end
        end
        S_BREAKWAIT: begin
          if (w_rx) w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_n;
      r_os_cnt  <= w_os_n;
      r_bit_cnt <= w_bit_n;
    end
  end

  // Character assembly; line format is frozen at the start bit.
  always_ff @(posedge clock) begin
    r_data     <= w_data_n;
    r_par_acc  <= w_par_n;
    r_all_zero <= w_zero_n;
    r_perr     <= w_perr_n;
    if (w_latch_cfg) begin
      r_cfg_bits   <= dataBits;
      r_cfg_par_en <= parityEnable;
      r_cfg_even   <= evenParity;
    end
  end

  assign w_wr_data = {~w_rx, r_perr, r_data};

  // FIFO: flush wins, a read frees room for a same-cycle write when full.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_rd    = fifoRe & ~w_empty & ~fifoFlush;
  assign w_wr    = w_wr_req & ~fifoFlush & ~reset & (~w_full | w_rd);
  assign w_ovr   = w_wr_req & ~fifoFlush & w_full & ~w_rd;

  always_ff @(posedge clock) begin
    if (reset || fifoFlush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + (AW + 1)'(1);
      else if (w_rd && !w_wr) r_count <= r_count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr] <= w_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovr <= 1'b0;
      r_brk <= 1'b0;
    end else begin
      r_ovr <= w_ovr;
      r_brk <= w_brk;
    end
  end

  // Character timeout: only idle-line ticks with data waiting are counted.
  assign w_to_clr = w_wr_req | w_rd | fifoFlush | w_empty;

  always_ff @(posedge clock) begin
    if (reset || w_to_clr) begin
      r_to_cnt <= '0;
      r_to_irq <= 1'b0;
    end else if (w_tick && (r_state == S_IDLE) && (r_to_cnt != TO_MAX)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
      if (r_to_cnt == TO_MAX - TO_W'(1)) r_to_irq <= 1'b1;
    end
  end

  assign w_head         = r_mem[r_rptr];
  assign w_thr          = (threshold == '0) ? (AW + 1)'(1) : {1'b0, threshold};
  assign dataOut        = w_empty ? 8'h00 : w_head[7:0];
  assign parityErrorOut = ~w_empty & w_head[8];
  assign frameErrorOut  = ~w_empty & w_head[9];
  assign fifoEmpty      = w_empty;
  assign fifoFull       = w_full;
  assign nrOfEntries    = r_count;
  assign rxAvailable    = (r_count >= w_thr);
  assign overrunError   = r_ovr;
  assign breakDetected  = r_brk;
  assign timeoutIrq     = r_to_irq;

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// Randomized bench for uart_rx_fifo_gen: serial frames are generated from the
// line format and the expected FIFO contents are kept in a queue model.
module tb_uart_rx_fifo_gen;

  localparam int FD      = 4;
  localparam int OS      = 16;
  localparam int DW      = 16;
  localparam int TOB     = 40;
  localparam int DIV     = 4;
  localparam int BIT_CYC = DIV * OS;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] baudDivisor = DW'(DIV);
  logic          rxLine = 1'b1;
  logic [1:0]    dataBits = 2'd3;
  logic          parityEnable = 1'b0;
  logic          evenParity = 1'b0;
  logic [1:0]    threshold = 2'd1;
  logic          fifoRe = 1'b0;
  logic          fifoFlush = 1'b0;
  logic [7:0]    dataOut;
  logic          frameErrorOut, parityErrorOut, fifoEmpty, fifoFull;
  logic [2:0]    nrOfEntries;
  logic          overrunError, breakDetected, rxAvailable, timeoutIrq;

  uart_rx_fifo_gen #(
    .FIFO_DEPTH(FD), .OVERSAMPLE(OS), .DIV_WIDTH(DW), .TIMEOUT_BITS(TOB)
  ) dut (
    .clock(clock), .reset(reset), .baudDivisor(baudDivisor), .rxLine(rxLine),
    .dataBits(dataBits), .parityEnable(parityEnable), .evenParity(evenParity),
    .threshold(threshold), .fifoRe(fifoRe), .fifoFlush(fifoFlush),
    .dataOut(dataOut), .frameErrorOut(frameErrorOut), .parityErrorOut(parityErrorOut),
    .fifoEmpty(fifoEmpty), .fifoFull(fifoFull), .nrOfEntries(nrOfEntries),
    .overrunError(overrunError), .breakDetected(breakDetected),
    .rxAvailable(rxAvailable), .timeoutIrq(timeoutIrq)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  int ncyc = 0;
  int ovr_seen = 0, brk_seen = 0, ovr_exp = 0, brk_exp = 0;
  int stop_edge = 0, wr_edge_obs = -1;
  logic [9:0] model_q[$];

  always @(negedge clock) begin
    if (overrunError)  ovr_seen++;
    if (breakDetected) brk_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ncyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; fifoRe = 1'b0; fifoFlush = 1'b0; rxLine = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    ncyc = 0;
    model_q.delete();
  endtask

  task automatic flush();
    fifoFlush = 1'b1; step(); fifoFlush = 1'b0;
    model_q.delete();
  endtask

  task automatic check_fifo(input string tag);
    int n, thr;
    logic [9:0] h;
    n = model_q.size();
    thr = (threshold == 2'd0) ? 1 : int'(threshold);
    check({tag, ".cnt"}, int'(nrOfEntries), n);
    check({tag, ".empty"}, int'(fifoEmpty), int'(n == 0));
    check({tag, ".full"}, int'(fifoFull), int'(n == FD));
    check({tag, ".avail"}, int'(rxAvailable), int'(n >= thr));
    if (n > 0) begin
      h = model_q[0];
      check({tag, ".data"}, int'(dataOut), int'(h[7:0]));
      check({tag, ".perr"}, int'(parityErrorOut), int'(h[8]));
      check({tag, ".ferr"}, int'(frameErrorOut), int'(h[9]));
    end else begin
      check({tag, ".data0"}, int'(dataOut), 0);
    end
  endtask

  task automatic pop_check(input string tag);
    check_fifo(tag);
    fifoRe = 1'b1; step(); fifoRe = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check({tag, ".popcnt"}, int'(nrOfEntries), model_q.size());
  endtask

  // Sends one character, starting the start bit in phase with the baud tick so
  // the stop-bit sample edge is known: half a bit plus one bit per later field.
  task automatic send_frame(input logic [7:0] ch, input logic [1:0] db, input logic pen,
                            input logic ev, input logic bad_par, input logic bad_stop,
                            input logic rd_stop);
    int nb, nbt, d, n0;
    logic [7:0] mask, data;
    logic pbit, stp, pe, brk;
    logic [11:0] fb;
    bit seen;
    dataBits = db; parityEnable = pen; evenParity = ev; rxLine = 1'b1;
    repeat (16) step();
    while (((ncyc + 2) % DIV) != 0) step();
    nb   = int'(db) + 5;
    mask = 8'hFF >> (3 - int'(db));
    data = ch & mask;
    pbit = (^data) ^ ~ev ^ bad_par;
    stp  = ~bad_stop;
    fb   = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < nb; i++) fb[1 + i] = data[i];
    if (pen) fb[1 + nb] = pbit;
    nbt = nb + int'(pen) + 2;
    fb[nbt - 1] = stp;
    d = ncyc - 1;
    stop_edge = d + 3 + DIV * (OS / 2) + BIT_CYC * (nb + 1 + int'(pen));
    n0 = int'(nrOfEntries);
    seen = 1'b0;
    wr_edge_obs = -1;
    for (int k = 0; k < nbt * BIT_CYC; k++) begin
      rxLine = fb[k / BIT_CYC];
      fifoRe = rd_stop && (ncyc == stop_edge);
      step();
      if (!seen && int'(nrOfEntries) != n0) begin
        seen = 1'b1;
        wr_edge_obs = ncyc - 1;
      end
    end
    fifoRe = 1'b0;
    rxLine = 1'b1;
    pe  = pen && (((^data) ^ pbit) != ~ev);
    brk = (data == 8'h00) && (!pen || !pbit) && !stp;
    if (brk) brk_exp++;
    if (rd_stop && model_q.size() > 0) void'(model_q.pop_front());
    if (model_q.size() < FD) model_q.push_back({~stp, pe, data});
    else ovr_exp++;
  endtask

  initial begin
    logic [7:0] ch;
    do_reset();
    check("rst.cnt", int'(nrOfEntries), 0);
    check("rst.empty", int'(fifoEmpty), 1);
    check("rst.full", int'(fifoFull), 0);
    check("rst.data", int'(dataOut), 0);
    check("rst.flags", int'({frameErrorOut, parityErrorOut}), 0);
    check("rst.pulses", int'({overrunError, breakDetected}), 0);
    check("rst.irq", int'(timeoutIrq), 0);
    check("rst.avail", int'(rxAvailable), 0);

    // 8N1 0xA5, exact write edge, then character timeout and glitch rejection
    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a5.wredge", wr_edge_obs, stop_edge);
    check_fifo("a5");
    while (ncyc < stop_edge + TOB * OS * DIV) step();
    check("to.early", int'(timeoutIrq), 0);
    step();
    check("to.rise", int'(timeoutIrq), 1);
    repeat (20) step();
    check("to.hold", int'(timeoutIrq), 1);
    pop_check("to.pop");
    check("to.clr", int'(timeoutIrq), 0);
    rxLine = 1'b0; step(); step(); rxLine = 1'b1;
    repeat (400) step();
    check_fifo("glitch");

    // 7E1 with corrupted parity
    send_frame(8'h3C, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("7e1.data", int'(dataOut), 8'h3C);
    check("7e1.perr", int'(parityErrorOut), 1);
    pop_check("7e1");

    // overrun: five characters into a four-entry FIFO
    flush();
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_fifo("ovr");
    check("ovr.pulses", ovr_seen, ovr_exp);
    check("ovr.head", int'(dataOut), 8'h10);

    // full FIFO with a read coincident with the fifth stop sample
    flush();
    for (int i = 0; i < 4; i++) send_frame(8'(8'h20 + i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_fifo("rdwr");
    check("rdwr.ovr", ovr_seen, ovr_exp);
    for (int i = 0; i < 4; i++) pop_check("rdwr.drain");

    // break: line low for 20 bit times
    dataBits = 2'd3; parityEnable = 1'b0;
    rxLine = 1'b0;
    repeat (20 * BIT_CYC) step();
    model_q.push_back(10'h200);
    brk_exp++;
    check_fifo("brk.low");
    rxLine = 1'b1;
    repeat (2 * BIT_CYC) step();
    check("brk.pulse", brk_seen, brk_exp);
    send_frame(8'h6B, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_fifo("brk.after");
    pop_check("brk.pop1");
    pop_check("brk.pop2");

    // reset in the middle of a frame
    rxLine = 1'b0; repeat (BIT_CYC + 20) step();
    rxLine = 1'b1; repeat (BIT_CYC) step();
    do_reset();
    repeat (12 * BIT_CYC) step();
    check_fifo("midrst");

    // randomized formats, errors and thresholds
    for (int n = 0; n < 18; n++) begin
      ch = 8'($urandom_range(0, 255));
      threshold = 2'($urandom_range(0, 3));
      send_frame(ch, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), 1'b0);
      check_fifo("rnd");
      if (model_q.size() >= 3)
        while (model_q.size() > 0) pop_check("rnd.drain");
    end
    while (model_q.size() > 0) pop_check("rnd.final");
    check("end.ovr", ovr_seen, ovr_exp);
    check("end.brk", brk_seen, brk_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
